// File: rtl/split_stream_reorder_pkg.sv
// split_stream_pkg: bank state type and read-address helpers shared by split_stream_reorder.
package split_stream_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    function automatic int bitrev(input int k, input int nbits);
        int r = 0;
        for (int i = 0; i < nbits; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic int decim_addr(input int k, input int n, input int decim);
        return (k % (n / decim)) * decim + k / (n / decim);
    endfunction
endpackage

// File: rtl/split_stream_bank.sv
// split_stream_bank: N x WIDTH register bank, one synchronous write port, one asynchronous read port.
module split_stream_bank #(
    parameter int WIDTH = 33,
    parameter int N     = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem [N];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/split_stream_reorder.sv
// split_stream_reorder: ping-pong frame buffer emitting each frame regrouped by index mod DECIM.
// Define SPLIT_STREAM_BITREV_EN for full bit-reversed (DIT) read order.
module split_stream_reorder import split_stream_pkg::*; #(
    parameter int WIDTH = 33,
    parameter int N     = 8,
    parameter int DECIM = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DECIM)-1:0] m_group,
    output logic                     m_last
);
    localparam int AW = $clog2(N);
    localparam int GW = $clog2(DECIM);

    bank_state_e      st [2];
    bank_state_e      st_nxt [2];
    logic             wr_bank, rd_bank;
    logic [AW-1:0]    wr_cnt, rd_cnt, raddr;
    logic [GW-1:0]    grp;
    logic [WIDTH-1:0] rdata [2];
    logic             wr_en, ld, last;

    assign s_ready = rst && (st[wr_bank] == EMPTY || st[wr_bank] == FILLING);
    assign wr_en   = s_valid && s_ready;
    assign ld      = (!m_valid || m_ready) && st[rd_bank] == DRAINING;
    assign last    = rd_cnt == AW'(N - 1);

`ifdef SPLIT_STREAM_BITREV_EN
    assign raddr = AW'(bitrev(int'(rd_cnt), AW));
    assign grp   = GW'(bitrev(int'(rd_cnt), AW) % DECIM);
`else
    assign raddr = AW'(decim_addr(int'(rd_cnt), N, DECIM));
    assign grp   = GW'(int'(rd_cnt) / (N / DECIM));
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        split_stream_bank #(.WIDTH(WIDTH), .N(N)) u_bank (
            .clk  (clk),
            .we   (wr_en && wr_bank == 1'(b)),
            .waddr(wr_cnt),
            .wdata(s_data),
            .raddr(raddr),
            .rdata(rdata[b])
        );
    end

    // The idle bank is primed to DRAINING while the other drains, so frames leave back-to-back
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_nxt[i] = st[i];
            if (wr_en && wr_bank == 1'(i)) st_nxt[i] = wr_cnt == AW'(N - 1) ? FULL : FILLING;
            if (st[i] == FULL && (rd_bank == 1'(i) || st[rd_bank] == DRAINING)) st_nxt[i] = DRAINING;
            if (ld && last && rd_bank == 1'(i)) st_nxt[i] = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st[0]   <= EMPTY;
            st[1]   <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_group <= '0;
            m_last  <= 1'b0;
        end else begin
            st[0] <= st_nxt[0];
            st[1] <= st_nxt[1];
            if (wr_en) begin
                wr_cnt <= wr_cnt == AW'(N - 1) ? '0 : wr_cnt + 1'b1;
                if (wr_cnt == AW'(N - 1)) wr_bank <= !wr_bank;
            end
            if (ld) begin
                m_valid <= 1'b1;
                m_data  <= rdata[rd_bank];
                m_group <= grp;
                m_last  <= last;
                rd_cnt  <= last ? '0 : rd_cnt + 1'b1;
                if (last) rd_bank <= !rd_bank;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_split_stream_reorder.sv
// tb_split_stream_reorder: table vectors, corner sequences and a randomized scoreboard run.
module tb_split_stream_reorder;
    localparam int W = 33;
    localparam int N = 8;
    localparam int D = 2;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        int           grp;
        bit           last;
    } vec_t;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [W-1:0] s_data = '0, m_data;
    logic         s_valid = 0, s_ready, m_valid, m_ready = 0, m_last;
    logic [0:0]   m_group;

    logic [W-1:0] b_sd = '0, b_md;
    logic         b_sv = 0, b_sr, b_mv, b_mr = 0, b_ml;
    logic [1:0]   b_mg;

    split_stream_reorder #(.WIDTH(W), .N(N), .DECIM(D)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_group(m_group), .m_last(m_last)
    );

    split_stream_reorder #(.WIDTH(W), .N(N), .DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
        .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr), .m_group(b_mg), .m_last(b_ml)
    );

    int checks = 0, failures = 0;
    int ncall, acc, first_mv, last_acc, first_blk;
    bit stall;
    logic [W-1:0] held_d;
    logic [0:0]   held_g;
    logic         held_l;
    logic [W-1:0] fr_q[$], exp_d[$], cap_d[$];
    int           exp_g[$], cap_g[$];
    bit           exp_l[$], cap_l[$];
    vec_t         tv[8], tv4[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < $clog2(N); i++) begin
            r = r * 2 + k % 2;
            k = k / 2;
        end
        return r;
    endfunction

    // Expected output of one complete frame, built from the grouping rule itself
    task automatic model_frame;
        int k = 0;
`ifdef SPLIT_STREAM_BITREV_EN
        for (int j = 0; j < N; j++) begin
            exp_d.push_back(fr_q[rev(j)]);
            exp_g.push_back(rev(j) % D);
            exp_l.push_back(j == N - 1);
        end
`else
        for (int g = 0; g < D; g++)
            for (int i = 0; i < N; i++)
                if (i % D == g) begin
                    exp_d.push_back(fr_q[i]);
                    exp_g.push_back(g);
                    exp_l.push_back(k == N - 1);
                    k++;
                end
`endif
        fr_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 0;
        s_valid = 0;
        m_ready = 0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        fr_q.delete(); exp_d.delete(); exp_g.delete(); exp_l.delete();
        cap_d.delete(); cap_g.delete(); cap_l.delete();
        stall = 0; ncall = 0; acc = 0; first_mv = -1; last_acc = -1; first_blk = -1;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic cycle(input bit sv, input logic [W-1:0] sd, input bit mr);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        ncall++;
        if (stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, held_d);
            chk("hold_group", m_group, held_g);
            chk("hold_last", m_last, held_l);
        end
        if (m_valid && first_mv < 0) first_mv = ncall;
        if (sv && !s_ready && first_blk < 0) first_blk = ncall;
        if (sv && s_ready) begin
            acc++;
            last_acc = ncall;
            fr_q.push_back(sd);
            if (fr_q.size() == N) model_frame();
        end
        if (m_valid && m_ready) begin
            cap_d.push_back(m_data);
            cap_g.push_back(int'(m_group));
            cap_l.push_back(m_last);
            chk("out_expected", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
                chk("sb_data", m_data, exp_d.pop_front());
                chk("sb_group", m_group, exp_g.pop_front());
                chk("sb_last", m_last, exp_l.pop_front());
            end
        end
        stall  = m_valid && !m_ready;
        held_d = m_data;
        held_g = m_group;
        held_l = m_last;
    endtask

    initial begin
        int a_out[8], a_grp[8], b_out[8], b_grp[8];
        int b_acc, b_n;
`ifdef SPLIT_STREAM_BITREV_EN
        a_out = '{0, 4, 2, 6, 1, 5, 3, 7}; a_grp = '{0, 0, 0, 0, 1, 1, 1, 1};
        b_out = '{0, 4, 2, 6, 1, 5, 3, 7}; b_grp = '{0, 0, 2, 2, 1, 1, 3, 3};
`else
        a_out = '{0, 2, 4, 6, 1, 3, 5, 7}; a_grp = '{0, 0, 0, 0, 1, 1, 1, 1};
        b_out = '{0, 4, 1, 5, 2, 6, 3, 7}; b_grp = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif
        for (int i = 0; i < 8; i++) begin
            tv[i]  = '{W'(i), W'(a_out[i]), a_grp[i], i == 7};
            tv4[i] = '{W'(i), W'(b_out[i]), b_grp[i], i == 7};
        end

        #2 rst = 0;
        #1;
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_group", m_group, 0);
        chk("reset_m_last", m_last, 0);
        do_reset();
        #1 chk("post_reset_s_ready", s_ready, 1);

        for (int i = 0; i < 8; i++) cycle(1, tv[i].din, 1);
        repeat (14) cycle(0, '0, 1);
        chk("tbl_count", cap_d.size(), 8);
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            chk($sformatf("tbl_data[%0d]", i), cap_d[i], tv[i].dout);
            chk($sformatf("tbl_group[%0d]", i), cap_g[i], tv[i].grp);
            chk($sformatf("tbl_last[%0d]", i), cap_l[i], tv[i].last);
        end
        chk("latency", first_mv - last_acc - 1, 2);

        do_reset();
        repeat (24) cycle(1, W'(200 + acc), 0);
        chk("bp_accepted", acc, 16);
        chk("bp_first_block", first_blk, 17);
        chk("bp_no_output", cap_d.size(), 0);
        repeat (50) cycle(acc < 24, W'(200 + acc), 1);
        chk("bp_third_frame", acc, 24);
        chk("bp_out_count", cap_d.size(), 24);
        chk("bp_drained", exp_d.size(), 0);

        do_reset();
        for (int c = 0; c < 70; c++) cycle(acc < 16, W'(300 + acc), (c % 2) == 1);
        chk("tog_out_count", cap_d.size(), 16);

        do_reset();
        repeat (5) cycle(1, W'(50 + acc), 1);
        do_reset();
        repeat (8) cycle(1, W'(100 + acc), 1);
        repeat (14) cycle(0, '0, 1);
        chk("mid_rst_count", cap_d.size(), 8);
        if (cap_d.size() == 8) begin
            chk("mid_rst_first", cap_d[0], 100);
            chk("mid_rst_final", cap_d[7], 107);
        end

        do_reset();
        repeat (500) cycle(1'($urandom_range(0, 1)), W'({$urandom(), $urandom()}), $urandom_range(0, 3) != 0);
        repeat (40) cycle(0, '0, 1);
        chk("rnd_drained", exp_d.size(), 0);
        chk("rnd_partial", fr_q.size() < N, 1);

        do_reset();
        b_acc = 0;
        b_n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            b_sv = b_acc < 8;
            b_sd = W'(b_acc);
            b_mr = 1;
            #1;
            if (b_sv && b_sr) b_acc++;
            if (b_mv && b_mr) begin
                if (b_n < 8) begin
                    chk($sformatf("d4_data[%0d]", b_n), b_md, tv4[b_n].dout);
                    chk($sformatf("d4_group[%0d]", b_n), b_mg, tv4[b_n].grp);
                    chk($sformatf("d4_last[%0d]", b_n), b_ml, tv4[b_n].last);
                end
                b_n++;
            end
        end
        chk("d4_count", b_n, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
